// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the word-serial wide adder.
//   WORD_W          : width of one operand word, i.e. the width of the adder slice
//   DEFAULT_NWORDS  : default number of words per operand
//   state_t / ST_*  : FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
package wide_add_sequencer_pkg;

    localparam int WORD_W         = 32;
    localparam int DEFAULT_NWORDS = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/wide_add_sequencer_cla32.sv
// 32-bit carry-lookahead adder using a recursive-doubling (Kogge-Stone)
// prefix network over generate/propagate pairs.
//   A, B  : 32-bit addends
//   Cin   : carry into bit 0
//   Sum   : A + B + Cin, low 32 bits
//   Carry : carry out of bit 31
module wide_add_sequencer_cla32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Carry
);

    logic [31:0] p;
    logic [31:0] g;
    logic [31:0] gp;
    logic [31:0] pp;
    logic [31:0] gn;
    logic [31:0] pn;

    always_comb begin
        p  = A ^ B;
        g  = A & B;
        // Folding Cin into bit 0's generate makes gp[i] the carry out of bit i
        // once the prefix network has run.
        gp    = g;
        gp[0] = g[0] | (p[0] & Cin);
        pp    = p;
        gn    = gp;
        pn    = pp;
        for (int d = 1; d < 32; d = d * 2) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= d) begin
                    gn[i] = gp[i] | (pp[i] & gp[i-d]);
                    pn[i] = pp[i] & pp[i-d];
                end else begin
                    gn[i] = gp[i];
                    pn[i] = pp[i];
                end
            end
            gp = gn;
            pp = pn;
        end
        Sum   = p ^ {gp[30:0], Cin};
        Carry = gp[31];
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial wide adder: adds two W = 32*NWORDS bit operands one 32-bit
// word per clock through a single shared CLA, least significant word first.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin captured in IDLE)
//   out_valid/out_ready : result handshake (sum, cout, ovf held in DONE)
//   sum, cout, ovf      : a+b+cin mod 2^W, carry out, signed overflow
//   fsm_state           : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, where the
// result stays constant until out_ready is seen. Inputs are ignored while
// not in IDLE.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int NWORDS = DEFAULT_NWORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] a,
    input  logic [WORD_W*NWORDS-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] sum,
    output logic                     cout,
    output logic                     ovf,
    output state_t                   fsm_state
);

    localparam int W     = WORD_W * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [W-1:0]       sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [WORD_W-1:0]  a_word;
    logic [WORD_W-1:0]  b_word;
    logic [WORD_W-1:0]  cla_sum;
    logic               cla_carry;

    assign a_word = a_q[WORD_W*int'(idx) +: WORD_W];
    assign b_word = b_q[WORD_W*int'(idx) +: WORD_W];

    wide_add_sequencer_cla32 cla32 (
        .A     (a_word),
        .B     (b_word),
        .Cin   (carry_q),
        .Sum   (cla_sum),
        .Carry (cla_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        // Start each operation from a clean partial result.
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[WORD_W*int'(idx) +: WORD_W] <= cla_sum;
                    carry_q <= cla_carry;
                    if (idx == LAST_IDX) begin
                        cout_q <= cla_carry;
                        // The top word's sum MSB is the result sign bit.
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) &&
                                  (cla_sum[WORD_W-1] != a_q[W-1]);
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign fsm_state = state;

endmodule
